// File: rtl/lstm_seq_ctrl.sv
// Sequencer that steps an external LSTM cell through up to SEQ_LEN_MAX timesteps,
// feeding back the hidden state and guarding each cell run with a watchdog.
module lstm_seq_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SEQ_LEN_MAX = 8,
  parameter int unsigned TIMEOUT     = 63
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seq_start,
  input  logic [3:0]              seq_len,
  input  logic                    seq_abort,
  input  logic                    x_valid,
  input  logic [4*DATA_WIDTH-1:0] x_data,
  output logic                    x_ready,
  output logic                    core_start,
  output logic [4*DATA_WIDTH-1:0] core_x,
  output logic [4*DATA_WIDTH-1:0] core_y_in,
  input  logic                    core_finished,
  input  logic [4*DATA_WIDTH-1:0] core_y_out,
  output logic                    h_valid,
  output logic [4*DATA_WIDTH-1:0] h_data,
  output logic [3:0]              h_step,
  output logic                    busy,
  output logic                    seq_done,
  output logic                    error
);

  localparam logic [5:0] WDOG_LAST = 6'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_X,
    S_START,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              len_q, len_d;
  logic [3:0]              step_q, step_d;
  logic                    start_cnt_q, start_cnt_d;
  logic [5:0]              wdog_q, wdog_d;
  logic [4*DATA_WIDTH-1:0] core_x_q, core_x_d;
  logic [4*DATA_WIDTH-1:0] h_data_q, h_data_d;
  logic [3:0]              h_step_q, h_step_d;
  logic                    h_valid_q, h_valid_d;
  logic                    seq_done_q, seq_done_d;
  logic                    error_q, error_d;
  logic                    len_ok;

  assign len_ok = (seq_len != 4'd0) && (32'(seq_len) <= SEQ_LEN_MAX);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    step_d      = step_q;
    start_cnt_d = start_cnt_q;
    wdog_d      = wdog_q;
    core_x_d    = core_x_q;
    h_data_d    = h_data_q;
    h_step_d    = h_step_q;
    h_valid_d   = 1'b0;
    seq_done_d  = 1'b0;
    error_d     = error_q;
    case (state_q)
      S_IDLE: begin
        if (seq_start && len_ok) begin
          len_d    = seq_len;
          h_data_d = '0;
          step_d   = '0;
          h_step_d = '0;
          state_d  = S_WAIT_X;
        end
      end
      S_WAIT_X: begin
        if (seq_abort) begin
          state_d = S_IDLE;
        end else if (x_valid) begin
          core_x_d    = x_data;
          start_cnt_d = 1'b0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (seq_abort) begin
          state_d = S_IDLE;
        end else if (start_cnt_q) begin
          wdog_d  = '0;
          state_d = S_RUN;
        end else begin
          start_cnt_d = 1'b1;
        end
      end
      S_RUN: begin
        // abort wins over a coincident finish; a finish on the last watchdog cycle still counts
        if (seq_abort) begin
          state_d = S_IDLE;
        end else if (core_finished) begin
          h_data_d  = core_y_out;
          h_valid_d = 1'b1;
          h_step_d  = step_q;
          if (step_q == len_q - 4'd1) begin
            state_d = S_DONE;
          end else begin
            step_d  = step_q + 4'd1;
            state_d = S_WAIT_X;
          end
        end else if (wdog_q == WDOG_LAST) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else begin
          wdog_d = wdog_q + 6'd1;
        end
      end
      S_DONE: begin
        seq_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        if (seq_abort) begin
          error_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      step_q      <= '0;
      start_cnt_q <= 1'b0;
      wdog_q      <= '0;
      core_x_q    <= '0;
      h_data_q    <= '0;
      h_step_q    <= '0;
      h_valid_q   <= 1'b0;
      seq_done_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      step_q      <= step_d;
      start_cnt_q <= start_cnt_d;
      wdog_q      <= wdog_d;
      core_x_q    <= core_x_d;
      h_data_q    <= h_data_d;
      h_step_q    <= h_step_d;
      h_valid_q   <= h_valid_d;
      seq_done_q  <= seq_done_d;
      error_q     <= error_d;
    end
  end

  assign x_ready    = (state_q == S_WAIT_X);
  assign core_start = (state_q == S_START) && !seq_abort && !rst;
  assign core_x     = core_x_q;
  assign core_y_in  = h_data_q;
  assign h_valid    = h_valid_q;
  assign h_data     = h_data_q;
  assign h_step     = h_step_q;
  assign busy       = (state_q != S_IDLE);
  assign seq_done   = seq_done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl: table of sequence runs against a behavioural cell model,
// with scoreboard queues for cell launches and hidden-state results.
module tb_lstm_seq_ctrl;

  localparam logic [31:0] CELL_K = 32'hAFC61734;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seq_start = 1'b0;
  logic [3:0]  seq_len = '0;
  logic        seq_abort = 1'b0;
  logic        x_valid = 1'b0;
  logic [31:0] x_data = '0;
  logic        x_ready;
  logic        core_start;
  logic [31:0] core_x;
  logic [31:0] core_y_in;
  logic        core_finished = 1'b0;
  logic [31:0] core_y_out = '0;
  logic        h_valid;
  logic [31:0] h_data;
  logic [3:0]  h_step;
  logic        busy;
  logic        seq_done;
  logic        error;

  lstm_seq_ctrl #(.DATA_WIDTH(8), .SEQ_LEN_MAX(8), .TIMEOUT(63)) dut (
    .clk(clk), .rst(rst), .seq_start(seq_start), .seq_len(seq_len),
    .seq_abort(seq_abort), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .core_start(core_start), .core_x(core_x), .core_y_in(core_y_in),
    .core_finished(core_finished), .core_y_out(core_y_out), .h_valid(h_valid),
    .h_data(h_data), .h_step(h_step), .busy(busy), .seq_done(seq_done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] x; logic [31:0] y; } start_t;
  typedef struct { logic [31:0] h; logic [3:0] step; } hexp_t;
  typedef struct { logic [3:0] len; logic [31:0] xb; bit poke; bit accept; } vec_t;

  start_t startq[$];
  hexp_t  hq[$];
  vec_t   tbl[6];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fin_cyc  = -100;
  int start_cyc = 0;
  int err_cyc  = 0;
  int err_rises = 0;
  int done_cnt = 0;
  bit cell_hang = 1'b0;
  int man_req = 0;
  logic [31:0] man_y = '0;

  function automatic logic [31:0] cell_f(input logic [31:0] x, input logic [31:0] y);
    return x ^ {y[23:0], y[31:24]} ^ CELL_K;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Cell model: answers 10 cycles after a core_start rise, or on a manual request.
  initial begin : cell_model
    int   cnt;
    bit   armed;
    logic cm_prev;
    int   man_seen;
    logic [31:0] pend_y;
    cnt = 0; armed = 0; cm_prev = 0; man_seen = 0; pend_y = '0;
    forever begin
      @(posedge clk);
      #1;
      core_finished = 1'b0;
      if (man_req != man_seen) begin
        man_seen = man_req;
        core_finished = 1'b1;
        core_y_out = man_y;
      end else if (!cell_hang) begin
        if (core_start && !cm_prev) begin
          pend_y = cell_f(core_x, core_y_in);
          cnt = 10;
          armed = 1;
        end else if (armed) begin
          cnt--;
          if (cnt == 0) begin
            core_finished = 1'b1;
            core_y_out = pend_y;
            armed = 0;
          end
        end
      end
      cm_prev = core_start;
    end
  end

  // Monitor: samples on the falling edge and checks against the scoreboard queues.
  initial begin : monitor
    logic cs_prev, err_prev;
    int cs_len;
    start_t s;
    hexp_t e;
    cs_prev = 0; err_prev = 0; cs_len = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (core_start === 1'b1) begin
          if (!cs_prev) begin
            start_cyc = cyc;
            if (startq.size() == 0) chk("unexpected_core_start", 32'(core_start), 0);
            else begin
              s = startq.pop_front();
              chk("core_x", core_x, s.x);
              chk("core_y_in", core_y_in, s.y);
            end
          end
          cs_len++;
        end else if (cs_prev) begin
          chk("core_start_len", 32'(cs_len), 2);
          cs_len = 0;
        end
        if (core_finished) fin_cyc = cyc;
        if (h_valid === 1'b1) begin
          if (hq.size() == 0) chk("unexpected_h_valid", 32'(h_valid), 0);
          else begin
            e = hq.pop_front();
            chk("h_data", h_data, e.h);
            chk("h_step", 32'(h_step), 32'(e.step));
            chk("h_valid_latency", 32'(cyc - fin_cyc), 1);
          end
        end
        if (seq_done === 1'b1) begin
          done_cnt++;
          chk("seq_done_latency", 32'(cyc - fin_cyc), 2);
        end
        if (error === 1'b1 && !err_prev) begin
          err_cyc = cyc;
          err_rises++;
        end
      end
      cs_prev  = (core_start === 1'b1);
      err_prev = (error === 1'b1);
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (x_ready) return;
      @(negedge clk);
    end
    chk("x_ready_timeout", 32'(x_ready), 1);
  endtask

  task automatic start_req(input logic [3:0] len);
    @(negedge clk);
    seq_start = 1'b1;
    seq_len   = len;
    @(negedge clk);
    seq_start = 1'b0;
    seq_len   = '0;
  endtask

  task automatic send_x(input logic [31:0] x);
    wait_ready();
    x_valid = 1'b1;
    x_data  = x;
    @(negedge clk);
    x_valid = 1'b0;
  endtask

  task automatic run_seq(input logic [3:0] len, input logic [31:0] xb, input bit poke);
    logic [31:0] hprev, x, h;
    int d0;
    start_req(len);
    chk("accept_busy", 32'(busy), 1);
    chk("accept_h_cleared", h_data, 0);
    hprev = '0;
    d0 = done_cnt;
    for (int k = 0; k < int'(len); k++) begin
      x = xb + 32'(k) * 32'h01020304;
      h = cell_f(x, hprev);
      startq.push_back('{x: x, y: hprev});
      hq.push_back('{h: h, step: 4'(k)});
      send_x(x);
      if (poke && k == 0) begin
        repeat (4) @(negedge clk);
        seq_start = 1'b1;
        seq_len   = 4'd1;
        @(negedge clk);
        seq_start = 1'b0;
        seq_len   = '0;
      end
      hprev = h;
    end
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != d0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("seq_done_count", 32'(done_cnt - d0), 1);
    chk("idle_after_done", 32'(busy), 0);
    chk("h_data_retained", h_data, hprev);
    chk("h_step_retained", 32'(h_step), 32'(len) - 1);
    chk("h_queue_drained", 32'(hq.size()), 0);
  endtask

  task automatic reject(input logic [3:0] len);
    start_req(len);
    for (int i = 0; i < 3; i++) begin
      chk("reject_busy", 32'(busy), 0);
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    logic [31:0] h0, x0, x1;
    int d0, r0;
    tbl[0] = '{len: 4'd1, xb: 32'hEBF53525, poke: 1'b0, accept: 1'b1};
    tbl[1] = '{len: 4'd5, xb: 32'h11223344, poke: 1'b0, accept: 1'b1};
    tbl[2] = '{len: 4'd0, xb: 32'h0,        poke: 1'b0, accept: 1'b0};
    tbl[3] = '{len: 4'd9, xb: 32'h0,        poke: 1'b0, accept: 1'b0};
    tbl[4] = '{len: 4'd3, xb: 32'h0A0B0C0D, poke: 1'b1, accept: 1'b1};
    tbl[5] = '{len: 4'd8, xb: 32'h01010101, poke: 1'b0, accept: 1'b1};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_x_ready", 32'(x_ready), 0);
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_core_x", core_x, 0);
    chk("rst_core_y_in", core_y_in, 0);
    chk("rst_h_valid", 32'(h_valid), 0);
    chk("rst_h_data", h_data, 0);
    chk("rst_h_step", 32'(h_step), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_seq_done", 32'(seq_done), 0);
    chk("rst_error", 32'(error), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].accept) run_seq(tbl[i].len, tbl[i].xb, tbl[i].poke);
      else reject(tbl[i].len);
    end

    // Watchdog timeout, error hold, abort out of ERR.
    cell_hang = 1'b1;
    r0 = err_rises;
    start_req(4'd2);
    startq.push_back('{x: 32'h5A5A5A5A, y: 32'h0});
    send_x(32'h5A5A5A5A);
    for (int i = 0; i < 200; i++) begin
      if (err_rises != r0) break;
      @(negedge clk);
    end
    chk("error_raised", 32'(err_rises - r0), 1);
    chk("timeout_latency", 32'(err_cyc - start_cyc), 65);
    repeat (5) @(negedge clk);
    chk("error_held", 32'(error), 1);
    chk("busy_in_err", 32'(busy), 1);
    seq_abort = 1'b1;
    @(negedge clk);
    seq_abort = 1'b0;
    chk("error_cleared", 32'(error), 0);
    chk("idle_after_err_abort", 32'(busy), 0);
    cell_hang = 1'b0;
    run_seq(4'd2, 32'h31415926, 1'b0);

    // Abort coincident with core_finished in RUN.
    cell_hang = 1'b1;
    x0 = 32'h13572468;
    x1 = 32'h24681357;
    h0 = cell_f(x0, 32'h0);
    start_req(4'd2);
    startq.push_back('{x: x0, y: 32'h0});
    hq.push_back('{h: h0, step: 4'd0});
    send_x(x0);
    repeat (3) @(negedge clk);
    man_y = h0;
    man_req++;
    startq.push_back('{x: x1, y: h0});
    send_x(x1);
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    man_y = 32'hDEADBEEF;
    man_req++;
    @(posedge clk);
    #2 seq_abort = 1'b1;
    @(posedge clk);
    #2 seq_abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 0);
    chk("abort_h_data_kept", h_data, h0);
    chk("abort_h_step_kept", 32'(h_step), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_seq_done", 32'(done_cnt - d0), 0);
    chk("abort_h_queue", 32'(hq.size()), 0);
    cell_hang = 1'b0;

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lstm_seq_ctrl.md
LSTM_SEQ_CTRL -- requirements
Module: lstm_seq_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one vector lane; all vectors are 4 lanes, packed lane 0 in bits [DATA_WIDTH-1:0].
REQ-002 Parameter SEQ_LEN_MAX, default 8: maximum timesteps per sequence.
REQ-003 Parameter TIMEOUT, default 63: maximum RUN cycles before error.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 seq_start  in  1  request to begin a sequence.
REQ-008 seq_len  in  4  timesteps in the sequence; sampled with seq_start.
REQ-009 seq_abort  in  1  abandon the current sequence.
REQ-010 x_valid  in  1  input vector valid.
REQ-011 x_data  in  4*DATA_WIDTH  input vector for the next timestep.
REQ-012 x_ready  out  1  controller accepts x_data.
REQ-013 core_start  out  1  start to the LSTM cell.
REQ-014 core_x  out  4*DATA_WIDTH  x vector to the cell.
REQ-015 core_y_in  out  4*DATA_WIDTH  recurrent hidden state to the cell.
REQ-016 core_finished  in  1  cell done pulse.
REQ-017 core_y_out  in  4*DATA_WIDTH  cell result, valid while core_finished=1.
REQ-018 h_valid  out  1  one-cycle pulse: new hidden state available.
REQ-019 h_data  out  4*DATA_WIDTH  current hidden state register.
REQ-020 h_step  out  4  timestep index of the last h_valid, 0-based.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 seq_done  out  1  one-cycle pulse at normal sequence completion.
REQ-023 error  out  1  watchdog timeout flag.

Function
REQ-024 States SHALL be IDLE, WAIT_X, START, RUN, DONE, ERR.
REQ-025 IDLE: seq_start=1 with 1<=seq_len<=SEQ_LEN_MAX SHALL latch seq_len, clear h_data to 0, clear step to 0, and go to WAIT_X. Any other seq_len value SHALL be ignored, and the block SHALL stay in IDLE.
REQ-026 seq_start outside IDLE SHALL be ignored.
REQ-027 WAIT_X: x_ready=1, and x_ready=0 in every other state. On x_valid&x_ready the block SHALL latch x_data into core_x and go to START.
REQ-028 START: core_start=1 for exactly 2 consecutive cycles, then go to RUN. Handshake at cycle T gives core_start high at T+1 and T+2.
REQ-029 core_x and core_y_in SHALL be held stable from START entry until the RUN exit; core_y_in SHALL equal h_data.
REQ-030 RUN: the watchdog SHALL count cycles from RUN entry.
REQ-031 RUN: core_finished=1 SHALL load core_y_out into h_data, pulse h_valid the next cycle with h_step=step, and then:
  - go to DONE if step==len-1;
  - otherwise increment step and go to WAIT_X.
REQ-032 If the watchdog reaches TIMEOUT without core_finished, the block SHALL go to ERR and set error=1.
REQ-033 core_finished outside RUN SHALL be ignored (no h_data update, no h_valid).
REQ-034 DONE: seq_done=1 for one cycle, then go to IDLE. h_data and h_step SHALL be retained until the next accepted seq_start.
REQ-035 ERR: error SHALL stay 1 until seq_abort or rst; seq_abort in ERR SHALL clear error and go to IDLE.
REQ-036 seq_abort in WAIT_X, START or RUN SHALL go to IDLE next cycle:
  - core_start=0 immediately;
  - no h_valid and no seq_done;
  - seq_abort beats core_finished in the same cycle;
  - seq_abort in IDLE or DONE SHALL have no effect.
REQ-037 Step counter SHALL be 4 bits and SHALL never wrap within a sequence.
REQ-038 Watchdog counter SHALL be 6 bits and SHALL clear on every RUN entry.

Reset
REQ-039 rst SHALL force IDLE. The following outputs SHALL all reset to 0: x_ready, core_start, core_x, core_y_in, h_valid, h_data, h_step, busy, seq_done, error.
REQ-040 rst mid-sequence SHALL abandon the sequence with no further core_start and no h_valid.
REQ-041 rst has priority over all other inputs.

Verification
REQ-042 Reset: hold rst 2 cycles -> all outputs 0, busy=0.
REQ-043 seq_len=1, x_data=32'hEB_F5_35_25, cell model finishes 10 cycles after core_start and returns 32'h44332211:
  - core_start high 2 cycles, core_y_in=0;
  - h_valid once, with h_data=32'h44332211 and h_step=0;
  - seq_done 2 cycles after core_finished.
REQ-044 seq_len=5 with five distinct x vectors:
  - five h_valid pulses with h_step 0..4;
  - core_y_in at step k equals the cell output of step k-1, and is 0 at step 0;
  - exactly one seq_done.
REQ-045 Cell model never finishes -> error=1 exactly 63 cycles after RUN entry. Then seq_abort -> error=0, IDLE. A new seq_start runs normally.
REQ-046 seq_abort coincident with core_finished in RUN -> IDLE, h_data unchanged, no h_valid, no seq_done.
REQ-047 Ignored requests:
  - seq_len=0 with seq_start -> busy stays 0;
  - seq_len=9 -> busy stays 0;
  - seq_start during RUN -> no effect on step or len.
